// File: rtl/mem_stage_lsu.sv
// Purpose : MEM pipeline stage; issues data-memory requests and drives the MEM/WB register.
// Latency : non-access instructions 1 cycle; loads/stores 1 issue cycle plus the wait for dmem_ack.
// Backpres: combinational stall holds IF/ID/EX and EX/MEM while a request is issued or outstanding.
//
// Ports:
//   clk, rst (async, active-high)
//   mem_to_reg_i, mem_write_i, reg_write_i, pc_count_i, rd2_i, alu_result_i  - EX/MEM inputs
//   dmem_req, dmem_we, dmem_addr, dmem_wdata (registered), dmem_rdata, dmem_ack - memory port
//   stall                                      - hold request to upstream stages
//   wb_mem_to_reg, wb_reg_write, wb_pc_count, wb_read_data, wb_alu_result - MEM/WB register
//   misalign_err                               - one-cycle pulse on a rejected misaligned access
//   bus_err                                    - sticky timeout flag (live only with MEM_TIMEOUT_EN)
//
// Build option: define MEM_TIMEOUT_EN to abandon a request after 256 WAIT cycles without ack.

module mem_stage_lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_to_reg_i,
    input  logic        mem_write_i,
    input  logic        reg_write_i,
    input  logic [31:0] pc_count_i,
    input  logic [31:0] rd2_i,
    input  logic [31:0] alu_result_i,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall,
    output logic        wb_mem_to_reg,
    output logic        wb_reg_write,
    output logic [31:0] wb_pc_count,
    output logic [31:0] wb_read_data,
    output logic [31:0] wb_alu_result,
    output logic        misalign_err,
    output logic        bus_err
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state;
    logic        access;
    logic        misaligned;
    logic        aligned_acc;
    logic        timeout_hit;

    // Transaction fields captured at issue; the address doubles as the ALU result
    // for writeback, so it is taken from dmem_addr rather than stored twice.
    logic        cap_load;
    logic        cap_reg_write;
    logic [31:0] cap_pc;

    assign access      = mem_to_reg_i | mem_write_i;
    assign misaligned  = access & (alu_result_i[1:0] != 2'b00);
    assign aligned_acc = access & ~misaligned;

`ifdef MEM_TIMEOUT_EN
    logic [7:0] wait_cnt;
    assign timeout_hit = (state == WAIT) & ~dmem_ack & (wait_cnt == 8'd255);
`else
    assign timeout_hit = 1'b0;
    assign bus_err     = 1'b0;
`endif

    // Upstream is released on the ack cycle (and on a timeout) so the next
    // instruction lands in EX/MEM at the same edge the current one retires.
    assign stall = ((state == IDLE) & aligned_acc)
                 | ((state == WAIT) & ~dmem_ack & ~timeout_hit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            dmem_addr     <= 32'd0;
            dmem_wdata    <= 32'd0;
            cap_load      <= 1'b0;
            cap_reg_write <= 1'b0;
            cap_pc        <= 32'd0;
            wb_mem_to_reg <= 1'b0;
            wb_reg_write  <= 1'b0;
            wb_pc_count   <= 32'd0;
            wb_read_data  <= 32'd0;
            wb_alu_result <= 32'd0;
            misalign_err  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            wait_cnt      <= 8'd0;
            bus_err       <= 1'b0;
`endif
        end else begin
            misalign_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (aligned_acc) begin
                        state         <= WAIT;
                        dmem_req      <= 1'b1;
                        dmem_we       <= mem_write_i;
                        dmem_addr     <= alu_result_i;
                        dmem_wdata    <= rd2_i;
                        // Both control bits set means store, never a load writeback.
                        cap_load      <= mem_to_reg_i & ~mem_write_i;
                        cap_reg_write <= reg_write_i;
                        cap_pc        <= pc_count_i;
                        wb_mem_to_reg <= 1'b0;
                        wb_reg_write  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
                        wait_cnt      <= 8'd0;
`endif
                    end else if (misaligned) begin
                        misalign_err  <= 1'b1;
                        wb_mem_to_reg <= 1'b0;
                        wb_reg_write  <= 1'b0;
                    end else begin
                        wb_mem_to_reg <= 1'b0;
                        wb_reg_write  <= reg_write_i;
                        wb_pc_count   <= pc_count_i;
                        wb_alu_result <= alu_result_i;
                        wb_read_data  <= 32'd0;
                    end
                end
                WAIT: begin
                    if (dmem_ack) begin
                        state         <= IDLE;
                        dmem_req      <= 1'b0;
                        dmem_we       <= 1'b0;
                        wb_mem_to_reg <= cap_load;
                        wb_reg_write  <= cap_reg_write;
                        wb_pc_count   <= cap_pc;
                        wb_alu_result <= dmem_addr;
                        wb_read_data  <= cap_load ? dmem_rdata : 32'd0;
                    end else if (timeout_hit) begin
                        // Abandoned request: retire it without a register write.
                        state         <= IDLE;
                        dmem_req      <= 1'b0;
                        dmem_we       <= 1'b0;
                        wb_mem_to_reg <= cap_load;
                        wb_reg_write  <= 1'b0;
                        wb_pc_count   <= cap_pc;
                        wb_alu_result <= dmem_addr;
                        wb_read_data  <= 32'd0;
`ifdef MEM_TIMEOUT_EN
                        bus_err       <= 1'b1;
`endif
                    end else begin
                        wb_mem_to_reg <= 1'b0;
                        wb_reg_write  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
                        wait_cnt      <= wait_cnt + 8'd1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Purpose : directed self-checking bench for mem_stage_lsu.
// Latency : inputs are driven 1 time unit after each rising edge, outputs sampled 1 unit later.
// Backpres: the bench plays the memory, driving dmem_ack/dmem_rdata by hand.

module tb_mem_stage_lsu;

    logic        clk;
    logic        rst;
    logic        mem_to_reg_i, mem_write_i, reg_write_i;
    logic [31:0] pc_count_i, rd2_i, alu_result_i;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_ack;
    logic        stall;
    logic        wb_mem_to_reg, wb_reg_write;
    logic [31:0] wb_pc_count, wb_read_data, wb_alu_result;
    logic        misalign_err, bus_err;

    int n_cmp;
    int n_bad;

    mem_stage_lsu dut (
        .clk           (clk),
        .rst           (rst),
        .mem_to_reg_i  (mem_to_reg_i),
        .mem_write_i   (mem_write_i),
        .reg_write_i   (reg_write_i),
        .pc_count_i    (pc_count_i),
        .rd2_i         (rd2_i),
        .alu_result_i  (alu_result_i),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_rdata    (dmem_rdata),
        .dmem_ack      (dmem_ack),
        .stall         (stall),
        .wb_mem_to_reg (wb_mem_to_reg),
        .wb_reg_write  (wb_reg_write),
        .wb_pc_count   (wb_pc_count),
        .wb_read_data  (wb_read_data),
        .wb_alu_result (wb_alu_result),
        .misalign_err  (misalign_err),
        .bus_err       (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic m2r, input logic mw, input logic rw,
                         input logic [31:0] pc, input logic [31:0] rd2, input logic [31:0] alu);
        mem_to_reg_i = m2r;
        mem_write_i  = mw;
        reg_write_i  = rw;
        pc_count_i   = pc;
        rd2_i        = rd2;
        alu_result_i = alu;
        #1;
    endtask

    int stall_cnt;
    int req_cnt;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        dmem_ack = 1'b0;
        dmem_rdata = 32'd0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        tick();
        tick();

        // Reset state
        chk("rst_req",   {31'd0, dmem_req}, 32'd0);
        chk("rst_we",    {31'd0, dmem_we}, 32'd0);
        chk("rst_addr",  dmem_addr, 32'd0);
        chk("rst_wdata", dmem_wdata, 32'd0);
        chk("rst_wbrw",  {31'd0, wb_reg_write}, 32'd0);
        chk("rst_wbrd",  wb_read_data, 32'd0);
        chk("rst_mis",   {31'd0, misalign_err}, 32'd0);
        chk("rst_buserr",{31'd0, bus_err}, 32'd0);
        rst = 1'b0;
        tick();

        // Load, ack three cycles after the request
        drive(1'b1, 1'b0, 1'b1, 32'h40, 32'h0, 32'h100);
        stall_cnt = 0;
        if (stall) stall_cnt++;
        tick();
        chk("ld_req",  {31'd0, dmem_req}, 32'd1);
        chk("ld_addr", dmem_addr, 32'h100);
        chk("ld_we",   {31'd0, dmem_we}, 32'd0);
        chk("ld_bubble", {31'd0, wb_reg_write}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            if (stall) stall_cnt++;
            chk("ld_req_hold", {31'd0, dmem_req}, 32'd1);
            tick();
        end
        dmem_ack = 1'b1;
        dmem_rdata = 32'hDEADBEEF;
        #1;
        chk("ld_stall_ack", {31'd0, stall}, 32'd0);
        chk("ld_stall_cnt", stall_cnt, 32'd4);
        tick();
        dmem_ack = 1'b0;
        dmem_rdata = 32'd0;
        drive(1'b0, 1'b0, 1'b0, 32'h44, 32'h0, 32'h0);
        chk("ld_wbrd",  wb_read_data, 32'hDEADBEEF);
        chk("ld_wbrw",  {31'd0, wb_reg_write}, 32'd1);
        chk("ld_wbm2r", {31'd0, wb_mem_to_reg}, 32'd1);
        chk("ld_wbpc",  wb_pc_count, 32'h40);
        chk("ld_wbalu", wb_alu_result, 32'h100);
        chk("ld_req_off", {31'd0, dmem_req}, 32'd0);

        // Store with zero-wait ack
        drive(1'b0, 1'b1, 1'b0, 32'h48, 32'h12345678, 32'h200);
        chk("st_stall_issue", {31'd0, stall}, 32'd1);
        tick();
        chk("st_we",    {31'd0, dmem_we}, 32'd1);
        chk("st_wdata", dmem_wdata, 32'h12345678);
        chk("st_addr",  dmem_addr, 32'h200);
        dmem_ack = 1'b1;
        #1;
        chk("st_stall_ack", {31'd0, stall}, 32'd0);
        tick();
        dmem_ack = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h4C, 32'h0, 32'h0);
        chk("st_we_off", {31'd0, dmem_we}, 32'd0);
        chk("st_req_off", {31'd0, dmem_req}, 32'd0);
        chk("st_wbrw",  {31'd0, wb_reg_write}, 32'd0);
        chk("st_wbrd",  wb_read_data, 32'd0);

        // ALU op, then back-to-back load and store (store with both bits set)
        drive(1'b0, 1'b0, 1'b1, 32'h50, 32'h0, 32'h0000A5A5);
        chk("alu_stall", {31'd0, stall}, 32'd0);
        tick();
        chk("alu_wbrw",  {31'd0, wb_reg_write}, 32'd1);
        chk("alu_wbalu", wb_alu_result, 32'h0000A5A5);
        chk("alu_wbpc",  wb_pc_count, 32'h50);
        drive(1'b1, 1'b0, 1'b1, 32'h54, 32'h0, 32'h300);
        tick();
        chk("b2b_ld_req",  {31'd0, dmem_req}, 32'd1);
        chk("b2b_ld_addr", dmem_addr, 32'h300);
        chk("b2b_bubble",  {31'd0, wb_reg_write}, 32'd0);
        chk("b2b_keep_alu", wb_alu_result, 32'h0000A5A5);
        dmem_ack = 1'b1;
        dmem_rdata = 32'hCAFEF00D;
        tick();
        dmem_ack = 1'b0;
        dmem_rdata = 32'd0;
        drive(1'b1, 1'b1, 1'b0, 32'h58, 32'h0BADF00D, 32'h304);
        chk("b2b_ld_wbrd", wb_read_data, 32'hCAFEF00D);
        chk("b2b_ld_wbrw", {31'd0, wb_reg_write}, 32'd1);
        chk("b2b_st_stall", {31'd0, stall}, 32'd1);
        tick();
        chk("b2b_st_req",   {31'd0, dmem_req}, 32'd1);
        chk("b2b_st_we",    {31'd0, dmem_we}, 32'd1);
        chk("b2b_st_addr",  dmem_addr, 32'h304);
        chk("b2b_st_wdata", dmem_wdata, 32'h0BADF00D);
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 32'h5C, 32'h0, 32'h77);
        chk("b2b_st_m2r",  {31'd0, wb_mem_to_reg}, 32'd0);
        chk("b2b_st_wbrd", wb_read_data, 32'd0);
        chk("b2b_st_wbpc", wb_pc_count, 32'h58);
        tick();
        chk("alu2_wbrw", {31'd0, wb_reg_write}, 32'd1);

        // Misaligned load
        drive(1'b1, 1'b0, 1'b1, 32'h60, 32'h0, 32'h103);
        chk("mis_stall", {31'd0, stall}, 32'd0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h64, 32'h0, 32'h0);
        chk("mis_req",    {31'd0, dmem_req}, 32'd0);
        chk("mis_pulse",  {31'd0, misalign_err}, 32'd1);
        chk("mis_bubble", {31'd0, wb_reg_write}, 32'd0);
        tick();
        chk("mis_pulse_end", {31'd0, misalign_err}, 32'd0);

        // Spurious ack in IDLE
        dmem_ack = 1'b1;
        #1;
        chk("spur_stall", {31'd0, stall}, 32'd0);
        tick();
        dmem_ack = 1'b0;
        chk("spur_req", {31'd0, dmem_req}, 32'd0);

        // Reset two cycles into WAIT
        drive(1'b1, 1'b0, 1'b1, 32'h70, 32'h0, 32'h400);
        tick();
        tick();
        chk("rw_req_before", {31'd0, dmem_req}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rw_req",    {31'd0, dmem_req}, 32'd0);
        chk("rw_addr",   dmem_addr, 32'd0);
        chk("rw_wbpc",   wb_pc_count, 32'd0);
        chk("rw_wbalu",  wb_alu_result, 32'd0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        rst = 1'b0;
        dmem_ack = 1'b1;
        dmem_rdata = 32'h11111111;
        tick();
        dmem_ack = 1'b0;
        chk("rw_no_wb",   {31'd0, wb_reg_write}, 32'd0);
        chk("rw_no_rd",   wb_read_data, 32'd0);
        chk("rw_req_off", {31'd0, dmem_req}, 32'd0);

        // Load that never receives an ack
        drive(1'b1, 1'b0, 1'b1, 32'h80, 32'h0, 32'h500);
        tick();
        req_cnt = 0;
`ifdef MEM_TIMEOUT_EN
        while (dmem_req && req_cnt < 400) begin
            req_cnt++;
            if (req_cnt == 256) chk("to_stall_low", {31'd0, stall}, 32'd0);
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 32'h84, 32'h0, 32'h0);
        chk("to_req_cycles", req_cnt, 32'd256);
        chk("to_buserr",     {31'd0, bus_err}, 32'd1);
        chk("to_wbrw",       {31'd0, wb_reg_write}, 32'd0);
        chk("to_wbrd",       wb_read_data, 32'd0);
        tick();
        tick();
        chk("to_buserr_sticky", {31'd0, bus_err}, 32'd1);
`else
        for (int i = 1; i < 300; i++) tick();
        chk("nto_stall_300", {31'd0, stall}, 32'd1);
        chk("nto_req_300",   {31'd0, dmem_req}, 32'd1);
        chk("nto_buserr",    {31'd0, bus_err}, 32'd0);
        dmem_ack = 1'b1;
        dmem_rdata = 32'h0000BEEF;
        tick();
        dmem_ack = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h84, 32'h0, 32'h0);
        chk("nto_late_rd", wb_read_data, 32'h0000BEEF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
